// File: rtl/forward_subst.sv
// Forward substitution L*y = b over IEEE-754 doubles, with one shared multicycle fpu.
// The fpu flushes subnormals to zero; rmode 2'b00 rounds to nearest even, other modes truncate.
module fpu (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  rmode,
  input  logic [2:0]  fpu_op,
  input  logic [63:0] opa,
  input  logic [63:0] opb,
  output logic [63:0] out,
  output logic        ready
);
  localparam logic [63:0] QNan = 64'h7FF8_0000_0000_0000;

  // sig = {hidden, 52 fraction, guard, round, sticky}; e is the biased exponent
  function automatic logic [63:0] round_pack(input logic s, input logic signed [13:0] e,
                                             input logic [55:0] sig, input logic [1:0] rm);
    logic [53:0]        m;
    logic signed [13:0] ex;
    logic               inc;
    inc = (rm == 2'b00) && sig[2] && (sig[3] || sig[1] || sig[0]);
    m   = {1'b0, sig[55:3]} + {53'd0, inc};
    ex  = e;
    if (m[53]) begin
      m  = m >> 1;
      ex = ex + 14'sd1;
    end
    if (!m[52] || ex <= 14'sd0) return {s, 63'd0};
    if (ex >= 14'sd2047) return {s, 11'h7FF, 52'd0};
    return {s, ex[10:0], m[51:0]};
  endfunction

  logic               sa, sb, a_zero, b_zero, a_spec, b_spec, a_nan, b_nan;
  logic [10:0]        ea, eb;
  logic [52:0]        ma, mb;
  logic signed [13:0] ea_s, eb_s;

  assign sa     = opa[63];
  assign sb     = opb[63] ^ (fpu_op == 3'b001);
  assign ea     = opa[62:52];
  assign eb     = opb[62:52];
  assign a_zero = (ea == 11'd0);
  assign b_zero = (eb == 11'd0);
  assign a_spec = &ea;
  assign b_spec = &eb;
  assign a_nan  = a_spec && (|opa[51:0]);
  assign b_nan  = b_spec && (|opb[51:0]);
  assign ma     = a_zero ? 53'd0 : {1'b1, opa[51:0]};
  assign mb     = b_zero ? 53'd0 : {1'b1, opb[51:0]};
  assign ea_s   = {3'b000, ea};
  assign eb_s   = {3'b000, eb};

  logic [105:0] prod;
  logic [63:0]  mul_res;
  always_comb begin
    prod    = {53'd0, ma} * {53'd0, mb};
    mul_res = {sa ^ sb, 63'd0};
    if (a_nan || b_nan || (a_spec && b_zero) || (b_spec && a_zero)) mul_res = QNan;
    else if (a_spec || b_spec) mul_res = {sa ^ sb, 11'h7FF, 52'd0};
    else if (!(a_zero || b_zero)) begin
      if (prod[105]) mul_res = round_pack(sa ^ sb, ea_s + eb_s - 14'sd1022,
                                          {prod[105:51], |prod[50:0]}, rmode);
      else           mul_res = round_pack(sa ^ sb, ea_s + eb_s - 14'sd1023,
                                          {prod[104:50], |prod[49:0]}, rmode);
    end
  end

  logic               swap, big_s;
  logic [10:0]        big_e, sml_e, dexp;
  logic [52:0]        big_m, sml_m;
  logic signed [13:0] big_es;
  logic [55:0]        bx, ext, al, diff;
  logic [56:0]        sum;
  int unsigned        lz;
  logic [63:0]        add_res;
  always_comb begin
    swap   = {eb, mb} > {ea, ma};
    big_s  = swap ? sb : sa;
    big_e  = swap ? eb : ea;
    sml_e  = swap ? ea : eb;
    big_m  = swap ? mb : ma;
    sml_m  = swap ? ma : mb;
    big_es = {3'b000, big_e};
    dexp   = big_e - sml_e;
    bx     = {big_m, 3'b000};
    ext    = {sml_m, 3'b000};
    // Alignment keeps the shifted-out bits as a jammed sticky bit
    if (dexp >= 11'd56) al = {55'd0, |sml_m};
    else al = (ext >> dexp) | {55'd0, |(ext & ((56'd1 << dexp) - 56'd1))};
    sum  = {1'b0, bx} + {1'b0, al};
    diff = bx - al;
    lz   = 0;
    for (int k = 0; k < 56; k++) if (diff[k]) lz = 55 - k;
    if (a_nan || b_nan || (a_spec && b_spec && (sa != sb))) add_res = QNan;
    else if (a_spec) add_res = {sa, 11'h7FF, 52'd0};
    else if (b_spec) add_res = {sb, 11'h7FF, 52'd0};
    else if (sa == sb) begin
      if (sum[56]) add_res = round_pack(sa, big_es + 14'sd1, {sum[56:2], sum[1] | sum[0]}, rmode);
      else         add_res = round_pack(sa, big_es, sum[55:0], rmode);
    end
    else if (diff == 56'd0) add_res = 64'd0;
    else add_res = round_pack(big_s, big_es - 14'(lz), diff << lz, rmode);
  end

  logic        div_spec;
  logic [63:0] div_spec_res;
  always_comb begin
    div_spec     = 1'b1;
    div_spec_res = {sa ^ sb, 63'd0};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_spec && b_spec)) div_spec_res = QNan;
    else if (a_spec || b_zero) div_spec_res = {sa ^ sb, 11'h7FF, 52'd0};
    else if (!(a_zero || b_spec)) div_spec = 1'b0;
  end

  // Restoring divider: 57 quotient bits (integer bit plus 56 fraction bits)
  logic               run_q, s_q, rem_ge;
  logic [5:0]         cnt_q;
  logic [53:0]        rem_q, rem_sub;
  logic [52:0]        dvs_q;
  logic [56:0]        q_q;
  logic signed [13:0] e_q;
  logic [1:0]         rm_q;

  assign rem_ge  = rem_q >= {1'b0, dvs_q};
  assign rem_sub = rem_ge ? rem_q - {1'b0, dvs_q} : rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out   <= '0;
      ready <= 1'b0;
      run_q <= 1'b0;
      s_q   <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      q_q   <= '0;
      e_q   <= '0;
      rm_q  <= '0;
    end else begin
      ready <= 1'b0;
      if (run_q) begin
        if (cnt_q != 6'd0) begin
          rem_q <= rem_sub << 1;
          q_q   <= {q_q[55:0], rem_ge};
          cnt_q <= cnt_q - 6'd1;
        end else begin
          run_q <= 1'b0;
          ready <= 1'b1;
          if (q_q[56]) out <= round_pack(s_q, e_q, {q_q[56:2], q_q[1] | q_q[0] | (|rem_q)}, rm_q);
          else out <= round_pack(s_q, e_q - 14'sd1, {q_q[55:1], q_q[0] | (|rem_q)}, rm_q);
        end
      end else if (enable) begin
        ready <= 1'b1;
        case (fpu_op)
          3'b000, 3'b001: out <= add_res;
          3'b010:         out <= mul_res;
          3'b011: begin
            if (div_spec) out <= div_spec_res;
            else begin
              ready <= 1'b0;
              run_q <= 1'b1;
              rem_q <= {1'b0, ma};
              dvs_q <= mb;
              q_q   <= '0;
              cnt_q <= 6'd57;
              s_q   <= sa ^ sb;
              e_q   <= ea_s - eb_s + 14'sd1023;
              rm_q  <= rmode;
            end
          end
          default: out <= '0;
        endcase
      end
    end
  end
endmodule

module forward_subst #(
  parameter int unsigned SIZE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SIZE*SIZE*64-1:0] factor,
  input  logic [SIZE*64-1:0]      vec_b,
  input  logic                    enable,
  output logic [SIZE*64-1:0]      y,
  output logic                    ready,
  output logic                    busy,
  output logic                    div_zero
);
  localparam int unsigned   IW    = $clog2(SIZE) + 1;
  localparam logic [IW-1:0] Last  = IW'(SIZE - 1);
  localparam logic [2:0]    OpAdd = 3'b000;
  localparam logic [2:0]    OpMul = 3'b010;
  localparam logic [2:0]    OpDiv = 3'b011;

  typedef enum logic [3:0] {
    StIdle, StRowInit, StMulIssue, StMulWait, StAddIssue, StAddWait, StDivIssue, StDivWait, StDone
  } state_e;

  state_e                  state_q;
  logic [SIZE*SIZE*64-1:0] l_q;
  logic [SIZE*64-1:0]      b_q, yint_q;
  logic [63:0]             acc_q, p_q, opa_q, opb_q, fpu_out, l_ij, l_ii, b_i, y_j;
  logic [2:0]              op_q;
  logic                    fpu_en_q, fpu_ready;
  logic [IW-1:0]           i_q, j_q, j_inc;

  assign j_inc = j_q + IW'(1);
  assign l_ij  = l_q[(int'(i_q) * SIZE + int'(j_q)) * 64 +: 64];
  assign l_ii  = l_q[(int'(i_q) * SIZE + int'(i_q)) * 64 +: 64];
  assign b_i   = b_q[int'(i_q) * 64 +: 64];
  assign y_j   = yint_q[int'(j_q) * 64 +: 64];

  fpu u_fpu (
    .clk   (clk),
    .rst   (rst),
    .enable(fpu_en_q),
    .rmode (2'b00),
    .fpu_op(op_q),
    .opa   (opa_q),
    .opb   (opb_q),
    .out   (fpu_out),
    .ready (fpu_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      l_q      <= '0;
      b_q      <= '0;
      yint_q   <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= OpAdd;
      fpu_en_q <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      y        <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      fpu_en_q <= 1'b0;
      unique case (state_q)
        StIdle: if (enable) begin
          l_q      <= factor;
          b_q      <= vec_b;
          i_q      <= '0;
          ready    <= 1'b0;
          div_zero <= 1'b0;
          busy     <= 1'b1;
          state_q  <= StRowInit;
        end
        StRowInit: begin
          acc_q   <= b_i;
          j_q     <= '0;
          state_q <= (i_q == '0) ? StDivIssue : StMulIssue;
        end
        StMulIssue: begin
          op_q     <= OpMul;
          opa_q    <= l_ij;
          opb_q    <= y_j;
          fpu_en_q <= 1'b1;
          state_q  <= StMulWait;
        end
        StMulWait: if (fpu_ready) begin
          p_q     <= fpu_out;
          state_q <= StAddIssue;
        end
        StAddIssue: begin
          // Flip the sign bit so acc - p works for products of either sign
          op_q     <= OpAdd;
          opa_q    <= acc_q;
          opb_q    <= {~p_q[63], p_q[62:0]};
          fpu_en_q <= 1'b1;
          state_q  <= StAddWait;
        end
        StAddWait: if (fpu_ready) begin
          acc_q   <= fpu_out;
          j_q     <= j_inc;
          state_q <= (j_inc == i_q) ? StDivIssue : StMulIssue;
        end
        StDivIssue: begin
          op_q     <= OpDiv;
          opa_q    <= acc_q;
          opb_q    <= l_ii;
          fpu_en_q <= 1'b1;
          if (l_ii[62:0] == 63'd0) div_zero <= 1'b1;
          state_q  <= StDivWait;
        end
        StDivWait: if (fpu_ready) begin
          yint_q[int'(i_q) * 64 +: 64] <= fpu_out;
          if (i_q == Last) state_q <= StDone;
          else begin
            i_q     <= i_q + IW'(1);
            state_q <= StRowInit;
          end
        end
        StDone: begin
          y       <= yint_q;
          ready   <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
